// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_pkg
// Purpose : Shared SoC definitions for the RAM arbiter: default bus widths,
//           the port indices used by the grant vector, the arbiter state
//           encoding and a small round-robin pick helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

  // Default widths of the requester / RAM buses.
  localparam int unsigned C_ADDR_W_DEF = 64;
  localparam int unsigned C_DATA_W_DEF = 64;
  localparam int unsigned C_BUS_W_DEF  = 3;   // log2(bytes per RAM cell)

  // Bit positions inside the two-entry request/grant vectors.
  localparam int unsigned C_PORT_I = 0;       // instruction fetch
  localparam int unsigned C_PORT_D = 1;       // data load/store

  // Arbiter state: idle, or holding a response for one of the two ports.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } arb_state_t;

  // Round-robin choice between two requesters. i_last_1 is set when
  // requester 1 won the previous grant, so requester 0 wins a tie now.
  function automatic logic [1:0] rr_pick(input logic [1:0] i_req,
                                         input logic       i_last_1);
    logic [1:0] v_grant;
    if (i_req == 2'b11) begin
      v_grant = i_last_1 ? 2'b01 : 2'b10;
    end else begin
      v_grant = i_req;
    end
    return v_grant;
  endfunction

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-requester round-robin arbiter with a one-bit last-grant
//           memory and a one-hot (or all-zero) combinational grant.
// Ports   : clk      in   clock
//           rst_n    in   synchronous active-low reset
//           i_req    in   [1:0] request vector (already qualified by caller)
//           o_grant  out  [1:0] one-hot grant, zero when nothing requests
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  // 1 = requester 1 received the most recent grant. Reset leaves requester 0
  // as the "last" winner so requester 1 has priority on the first tie.
  logic       r_last_1;
  logic [1:0] w_grant;

  assign w_grant = rr_pick(i_req, r_last_1);
  assign o_grant = w_grant;

  // A grant is always taken by the caller in the same cycle (grant doubles as
  // ready), so the history advances on every non-empty grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_1 <= 1'b0;
    end else if (|w_grant) begin
      r_last_1 <= w_grant[1];
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Shares one single-cycle RAM port between an instruction-fetch
//           requester and a data load/store requester. One transaction is
//           outstanding at a time; responses are registered and held until
//           the requester consumes them.
// Ports   : clk, rst_n                      clock, sync active-low reset
//           i_req_valid/addr, i_req_ready   fetch request handshake
//           i_rsp_valid/data/err, i_rsp_ready  fetch response handshake
//           d_req_valid/we/addr/wdata, d_req_ready  data request handshake
//           d_rsp_valid/data/err, d_rsp_ready  data response handshake
//           ram_rw, ram_addr, ram_write     RAM strobe, address, write data
//           ram_read, ram_exception         combinational RAM read / range flag
// Rev     : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = C_ADDR_W_DEF,
  parameter int unsigned DATA_W = C_DATA_W_DEF,
  parameter int unsigned BUS_W  = C_BUS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  // Instruction-fetch port (read only)
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_err,

  // Data port (load/store)
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,

  // RAM port
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  input  logic [DATA_W-1:0] ram_read,
  input  logic              ram_exception
);

  arb_state_t        r_state;

  logic              r_i_rsp_valid;
  logic [DATA_W-1:0] r_i_rsp_data;
  logic              r_i_rsp_err;
  logic              r_d_rsp_valid;
  logic [DATA_W-1:0] r_d_rsp_data;
  logic              r_d_rsp_err;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic [ADDR_W-1:0] w_addr;
  logic              w_misal;
  logic              w_store;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;

  // --------------------------------------------------------------------------
  // Arbitration. Requests only reach the arbiter while idle and out of reset,
  // so the grant is exactly the accept strobe for each port.
  // --------------------------------------------------------------------------
  assign w_req[C_PORT_I] = rst_n && (r_state == IDLE) && i_req_valid;
  assign w_req[C_PORT_D] = rst_n && (r_state == IDLE) && d_req_valid;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign w_gnt_i     = w_grant[C_PORT_I];
  assign w_gnt_d     = w_grant[C_PORT_D];
  assign i_req_ready = w_gnt_i;
  assign d_req_ready = w_gnt_d;

  // --------------------------------------------------------------------------
  // RAM access for the accepted request. Address and write data fall back to
  // zero whenever nothing is being accepted.
  // --------------------------------------------------------------------------
  assign w_addr  = w_gnt_d ? d_req_addr :
                   w_gnt_i ? i_req_addr : '0;
  assign w_misal = |w_addr[BUS_W-1:0];
  assign w_store = w_gnt_d && d_req_we;

  assign ram_addr  = w_addr;
  assign ram_write = w_store ? d_req_wdata : '0;
  // Never write a misaligned or out-of-range cell.
  assign ram_rw    = w_store && !w_misal && !ram_exception;

  // Response captured at accept: stores and misaligned accesses return zero,
  // anything misaligned or out of range reports an error.
  assign w_err   = ram_exception || w_misal;
  assign w_rdata = (w_store || w_misal) ? '0 : ram_read;

  // --------------------------------------------------------------------------
  // Transaction FSM with registered response outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_i_rsp_err   <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
      r_d_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_i) begin
            r_state       <= RESP_I;
            r_i_rsp_valid <= 1'b1;
            r_i_rsp_data  <= w_rdata;
            r_i_rsp_err   <= w_err;
          end else if (w_gnt_d) begin
            r_state       <= RESP_D;
            r_d_rsp_valid <= 1'b1;
            r_d_rsp_data  <= w_rdata;
            r_d_rsp_err   <= w_err;
          end
        end

        // Hold the response until consumed. Returning to IDLE here means the
        // next accept can happen at the earliest one cycle later.
        RESP_I: begin
          if (i_rsp_ready) begin
            r_state       <= IDLE;
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_data  <= '0;
            r_i_rsp_err   <= 1'b0;
          end
        end

        RESP_D: begin
          if (d_rsp_ready) begin
            r_state       <= IDLE;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
            r_d_rsp_err   <= 1'b0;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_i_rsp_valid <= 1'b0;
          r_d_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign i_rsp_err   = r_i_rsp_err;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;
  assign d_rsp_err   = r_d_rsp_err;

endmodule : ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: address width of requesters and RAM port.
REQ-002 Parameter DATA_W, default 64: data width of requesters and RAM port.
REQ-003 Parameter BUS_W, default 3: log2 of bytes per RAM cell; the low BUS_W address bits must be zero.
REQ-004 The block SHALL have one clock and a synchronous active-low reset (ports below).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 i_req_valid  in  1  instruction-fetch read request.
REQ-008 i_req_addr  in  ADDR_W  fetch byte address.
REQ-009 i_req_ready  out  1  fetch request accepted this cycle.
REQ-010 i_rsp_valid  out  1  fetch response valid.
REQ-011 i_rsp_ready  in  1  fetch response consumed.
REQ-012 i_rsp_data  out  DATA_W  fetch read data.
REQ-013 i_rsp_err  out  1  fetch error (range exception or misalignment).
REQ-014 d_req_valid  in  1  data load/store request.
REQ-015 d_req_we  in  1  1 = store, 0 = load.
REQ-016 d_req_addr  in  ADDR_W  data byte address.
REQ-017 d_req_wdata  in  DATA_W  store data.
REQ-018 d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_data, d_rsp_err  same as i_* equivalents, data port.
REQ-019 ram_rw  out  1  RAM write strobe, 1 = write.
REQ-020 ram_addr, ram_write  out  ADDR_W, DATA_W  RAM address and write data.
REQ-021 ram_read, ram_exception  in  DATA_W, 1  combinational RAM read data and out-of-range flag.

Function
REQ-022 FSM states: IDLE, RESP_I, RESP_D; the block SHALL allow one outstanding transaction in total.
REQ-023 In IDLE, i_req_ready/d_req_ready SHALL reflect the combinational grant; only one SHALL be high per cycle.
REQ-024 Arbitration SHALL be round-robin: if both ports are valid, the port not granted last time wins; after reset, data has priority.
REQ-025 In the accept cycle, the granted request SHALL drive ram_addr; ram_rw=1 only for a store with aligned address and ram_exception=0.
REQ-026 On accept, read data (0 for stores), err = ram_exception | misaligned, SHALL be registered; the state moves to RESP_I or RESP_D; latency is exactly 1 cycle from accept to rsp_valid.
REQ-027 A misaligned request (addr[BUS_W-1:0] != 0) SHALL complete with err=1 and data=0 and SHALL NOT write RAM.
REQ-028 In RESP_x, rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready; both req_ready outputs are 0.
REQ-029 On rsp_ready in RESP_x, the state SHALL return to IDLE; a new request is accepted at the earliest in the next cycle (no back-to-back in the same cycle).
REQ-030 Outside accept cycles, ram_rw SHALL be 0; ram_addr/ram_write SHALL be 0.
REQ-031 A request that is valid but not granted SHALL remain pending; no request is dropped.

Reset
REQ-032 While rst_n=0 at a rising edge: state=IDLE, last-grant=instruction (data wins next), both rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-033 While rst_n=0, ram_rw and both req_ready SHALL be 0; reset mid-transaction SHALL discard the pending response.

Structure
REQ-034 State encoding (IDLE, RESP_I, RESP_D) and the default widths SHALL reside in the shared SoC package.
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests, last-grant state, one-hot grant).

Verification
REQ-036 Reset, then d store addr 0x100 data 0xDEAD -> ram_rw=1 for one cycle, d_rsp_valid next cycle, err=0.
REQ-037 Both valid in IDLE after reset -> data granted first, then fetch; alternation over 4 requests: D,I,D,I.
REQ-038 Fetch addr 0x104 (misaligned) -> i_rsp_err=1, data 0, ram_rw never 1.
REQ-039 Load with ram_exception=1 -> d_rsp_err=1; hold d_rsp_ready=0 for 5 cycles -> response stable, both req_ready 0.
REQ-040 Reset asserted in RESP_I -> next cycle i_rsp_valid=0, state IDLE, data port wins the next contention.
